// File: rtl/servo_cmd_if.sv
// Request/grant handshake between the two position requesters and the servo scheduler.
interface servo_cmd_if;
  logic       req_a;
  logic [4:0] pos_a;
  logic       req_b;
  logic [4:0] pos_b;
  logic       gnt_a;
  logic       gnt_b;

  modport master (output req_a, pos_a, req_b, pos_b, input gnt_a, gnt_b);
  modport slave  (input req_a, pos_a, req_b, pos_b, output gnt_a, gnt_b);
endinterface

// File: rtl/servo_cmd_scheduler.sv
// Round-robin arbitration of two servo position requesters plus frame-aligned PWM
// generation with one-tick-per-frame slewing of the live pulse width.
module servo_cmd_scheduler #(
  parameter int FRAME_TICKS = 200,
  parameter int MIN_W       = 7,
  parameter int MAX_W       = 17
) (
  input  logic       clk_10KHz,
  input  logic       reset,
  servo_cmd_if.slave cmd,
  input  logic       enable,
  output logic       pwm_out,
  output logic [4:0] cur_width,
  output logic [4:0] target,
  output logic       moving,
  output logic       frame_sync
);
  localparam logic [7:0] LAST_TICK = 8'(FRAME_TICKS - 1);
  localparam logic [4:0] MIN_W5    = 5'(MIN_W);
  localparam logic [4:0] MAX_W5    = 5'(MAX_W);
  localparam logic [4:0] MID_W5    = 5'((MIN_W + MAX_W) / 2);

  typedef enum logic {IDLE = 1'b0, MOVE = 1'b1} state_t;
  typedef enum logic {GNT_A = 1'b0, GNT_B = 1'b1} owner_t;

  state_t     state, state_nxt;
  owner_t     last_gnt, last_gnt_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic [4:0] cur_width_nxt, target_nxt;
  logic       gnt_a_nxt, gnt_b_nxt;
  logic       wrap;

  function automatic logic [4:0] clamp_w(input logic [4:0] pos);
    if (pos < MIN_W5) return MIN_W5;
    if (pos > MAX_W5) return MAX_W5;
    return pos;
  endfunction

  assign wrap       = (cnt == LAST_TICK);
  assign cnt_nxt    = wrap ? 8'd0 : cnt + 8'd1;
  assign frame_sync = (cnt == 8'd0);
  assign moving     = (state == MOVE);

  always_ff @(posedge clk_10KHz or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    last_gnt_nxt  = last_gnt;
    target_nxt    = target;
    cur_width_nxt = cur_width;
    gnt_a_nxt     = 1'b0;
    gnt_b_nxt     = 1'b0;
    case (state)
      IDLE: begin
        // On a tie the requester that was not served last wins.
        if (cmd.req_a && (!cmd.req_b || last_gnt == GNT_B)) begin
          gnt_a_nxt    = 1'b1;
          target_nxt   = clamp_w(cmd.pos_a);
          last_gnt_nxt = GNT_A;
          state_nxt    = MOVE;
        end else if (cmd.req_b) begin
          gnt_b_nxt    = 1'b1;
          target_nxt   = clamp_w(cmd.pos_b);
          last_gnt_nxt = GNT_B;
          state_nxt    = MOVE;
        end
      end
      MOVE: begin
        if (cur_width == target)
          state_nxt = IDLE;
        else if (wrap)
          cur_width_nxt = (cur_width < target) ? cur_width + 5'd1 : cur_width - 5'd1;
      end
    endcase
  end

  // Width only steps at the wrap edge, so every frame carries one full, unchanged pulse.
  always_ff @(posedge clk_10KHz or posedge reset) begin
    if (reset) begin
      cnt       <= 8'd0;
      cur_width <= MID_W5;
      target    <= MID_W5;
      last_gnt  <= GNT_B;
      cmd.gnt_a <= 1'b0;
      cmd.gnt_b <= 1'b0;
      pwm_out   <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      cur_width <= cur_width_nxt;
      target    <= target_nxt;
      last_gnt  <= last_gnt_nxt;
      cmd.gnt_a <= gnt_a_nxt;
      cmd.gnt_b <= gnt_b_nxt;
      pwm_out   <= enable && ({3'b000, cur_width_nxt} > cnt_nxt);
    end
  end
endmodule

// File: tb/tb_servo_cmd_scheduler.sv
// Directed scenarios plus a randomized run against a frame-level reference model.
`timescale 1us/1ns
module tb_servo_cmd_scheduler;
  localparam int FRAME = 200;

  logic       clk_10KHz = 1'b0;
  logic       reset     = 1'b1;
  logic       enable    = 1'b1;
  logic       pwm_out, moving, frame_sync;
  logic [4:0] cur_width, target;
  int         checks   = 0;
  int         failures = 0;

  servo_cmd_if cmd();

  servo_cmd_scheduler #(.FRAME_TICKS(200), .MIN_W(7), .MAX_W(17)) dut (
    .clk_10KHz (clk_10KHz),
    .reset     (reset),
    .cmd       (cmd),
    .enable    (enable),
    .pwm_out   (pwm_out),
    .cur_width (cur_width),
    .target    (target),
    .moving    (moving),
    .frame_sync(frame_sync)
  );

  always #50 clk_10KHz = ~clk_10KHz;

  // Reference model: position within the frame, live width, goal, busy flag, fairness bit.
  int m_tick, m_width, m_goal;
  bit m_busy, m_prefer_a, m_gnt_a, m_gnt_b, m_pwm, m_wrap;

  function automatic int model_clamp(int p);
    if (p < 7)  return 7;
    if (p > 17) return 17;
    return p;
  endfunction

  always @(posedge clk_10KHz or posedge reset) begin
    if (reset) begin
      m_tick = 0; m_width = 12; m_goal = 12; m_busy = 0; m_prefer_a = 1;
      m_gnt_a = 0; m_gnt_b = 0; m_pwm = 0;
    end else begin
      m_wrap  = (m_tick == FRAME - 1);
      m_gnt_a = 0;
      m_gnt_b = 0;
      if (!m_busy) begin
        if (cmd.req_a && (!cmd.req_b || m_prefer_a)) begin
          m_gnt_a = 1; m_goal = model_clamp(int'(cmd.pos_a)); m_busy = 1; m_prefer_a = 0;
        end else if (cmd.req_b) begin
          m_gnt_b = 1; m_goal = model_clamp(int'(cmd.pos_b)); m_busy = 1; m_prefer_a = 1;
        end
      end else if (m_width == m_goal) begin
        m_busy = 0;
      end else if (m_wrap) begin
        m_width = m_width + ((m_goal > m_width) ? 1 : -1);
      end
      m_tick = (m_tick + 1) % FRAME;
      m_pwm  = enable && (m_tick < m_width);
    end
  end

  initial begin
    #(60000 * 100);
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk_10KHz);
  endtask

  task automatic do_reset();
    cmd.req_a = 1'b0; cmd.req_b = 1'b0; enable = 1'b1;
    reset = 1'b1; tick(); tick(); reset = 1'b0;
  endtask

  task automatic count_frame(output int highs, output bit found);
    highs = 0; found = 0;
    for (int i = 0; i < FRAME + 2 && !found; i++) begin
      if (frame_sync === 1'b1) found = 1;
      else tick();
    end
    if (found)
      for (int i = 0; i < FRAME; i++) begin
        if (pwm_out === 1'b1) highs++;
        tick();
      end
  endtask

  task automatic test_reset();
    int highs; bit found;
    cmd.req_a = 1'b1; cmd.pos_a = 5'd17;
    repeat (250) tick();
    cmd.req_a = 1'b0;
    reset = 1'b1;
    #1;
    checks++;
    if (pwm_out !== 1'b0 || cmd.gnt_a !== 1'b0 || cmd.gnt_b !== 1'b0 || cur_width !== 5'd12 ||
        target !== 5'd12 || frame_sync !== 1'b1 || moving !== 1'b0) begin
      failures++;
      $display("FAIL reset_async: pwm=%0b gnt=%0b%0b cur=%0d tgt=%0d fs=%0b mov=%0b, required 0 00 12 12 1 0",
               pwm_out, cmd.gnt_a, cmd.gnt_b, cur_width, target, frame_sync, moving);
    end
    tick(); reset = 1'b0; tick();
    count_frame(highs, found);
    checks++;
    if (!found || highs != 12) begin
      failures++;
      $display("FAIL reset_frame_width: found=%0b high=%0d, required 12", found, highs);
    end
  endtask

  task automatic test_single();
    int n; int highs; bit found;
    cmd.pos_a = 5'd17; cmd.req_a = 1'b1;
    n = 0;
    while (cmd.gnt_a !== 1'b1 && n < 10) begin tick(); n++; end
    checks++;
    if (cmd.gnt_a !== 1'b1 || target !== 5'd17 || moving !== 1'b1) begin
      failures++;
      $display("FAIL single_grant: gnt_a=%0b tgt=%0d mov=%0b, required 1 17 1", cmd.gnt_a, target, moving);
    end
    cmd.req_a = 1'b0;
    tick();
    checks++;
    if (cmd.gnt_a !== 1'b0) begin
      failures++;
      $display("FAIL single_gnt_pulse: gnt_a=%0b, required 0", cmd.gnt_a);
    end
    for (int k = 13; k <= 17; k++) begin
      found = 0;
      for (int i = 0; i < FRAME + 2 && !found; i++) begin
        if (frame_sync === 1'b1) found = 1;
        else tick();
      end
      checks++;
      if (!found || cur_width !== 5'(k) || moving !== 1'b1) begin
        failures++;
        $display("FAIL single_slew: cur=%0d mov=%0b, required %0d 1", cur_width, moving, k);
      end
      tick();
    end
    checks++;
    if (moving !== 1'b0) begin
      failures++;
      $display("FAIL single_settle: mov=%0b, required 0", moving);
    end
    count_frame(highs, found);
    checks++;
    if (!found || highs != 17) begin
      failures++;
      $display("FAIL single_frame_width: high=%0d, required 17", highs);
    end
  endtask

  task automatic test_round_robin();
    int n; logic [4:0] pa;
    do_reset();
    cmd.pos_a = 5'd7; cmd.pos_b = 5'd15; cmd.req_a = 1'b1; cmd.req_b = 1'b1;
    n = 0;
    while (cmd.gnt_a !== 1'b1 && cmd.gnt_b !== 1'b1 && n < 10) begin tick(); n++; end
    checks++;
    if (cmd.gnt_a !== 1'b1 || cmd.gnt_b !== 1'b0 || target !== 5'd7) begin
      failures++;
      $display("FAIL rr_first_tie: gnt=%0b%0b tgt=%0d, required 10 7", cmd.gnt_a, cmd.gnt_b, target);
    end
    cmd.req_a = 1'b0;
    n = 0;
    while (cmd.gnt_b !== 1'b1 && n < 7 * FRAME) begin tick(); n++; end
    checks++;
    if (cmd.gnt_b !== 1'b1 || cur_width !== 5'd7 || target !== 5'd15) begin
      failures++;
      $display("FAIL rr_b_after_settle: gnt_b=%0b cur=%0d tgt=%0d, required 1 7 15", cmd.gnt_b, cur_width, target);
    end
    cmd.req_b = 1'b0;
    n = 0;
    while (moving !== 1'b0 && n < 10 * FRAME) begin tick(); n++; end
    checks++;
    if (moving !== 1'b0 || cur_width !== 5'd15) begin
      failures++;
      $display("FAIL rr_b_settle: mov=%0b cur=%0d, required 0 15", moving, cur_width);
    end
    pa = 5'($urandom_range(7, 17));
    cmd.pos_a = pa; cmd.pos_b = 5'($urandom_range(0, 31));
    cmd.req_a = 1'b1; cmd.req_b = 1'b1;
    n = 0;
    while (cmd.gnt_a !== 1'b1 && cmd.gnt_b !== 1'b1 && n < 10) begin tick(); n++; end
    checks++;
    if (cmd.gnt_a !== 1'b1 || cmd.gnt_b !== 1'b0 || target !== pa) begin
      failures++;
      $display("FAIL rr_second_tie: gnt=%0b%0b tgt=%0d, required 10 %0d", cmd.gnt_a, cmd.gnt_b, target, pa);
    end
    cmd.req_a = 1'b0; cmd.req_b = 1'b0;
  endtask

  task automatic test_clamp();
    int n;
    do_reset();
    cmd.pos_b = 5'd3; cmd.req_b = 1'b1;
    n = 0;
    while (cmd.gnt_b !== 1'b1 && n < 10) begin tick(); n++; end
    checks++;
    if (cmd.gnt_b !== 1'b1 || target !== 5'd7) begin
      failures++;
      $display("FAIL clamp_low: gnt_b=%0b tgt=%0d, required 1 7", cmd.gnt_b, target);
    end
    cmd.req_b = 1'b0;
    n = 0;
    while (moving !== 1'b0 && n < 7 * FRAME) begin tick(); n++; end
    cmd.pos_a = 5'd31; cmd.req_a = 1'b1;
    n = 0;
    while (cmd.gnt_a !== 1'b1 && n < 10) begin tick(); n++; end
    checks++;
    if (cmd.gnt_a !== 1'b1 || target !== 5'd17) begin
      failures++;
      $display("FAIL clamp_high: gnt_a=%0b tgt=%0d, required 1 17", cmd.gnt_a, target);
    end
    cmd.req_a = 1'b0;
    n = 0;
    while (moving !== 1'b0 && n < 12 * FRAME) begin tick(); n++; end
    cmd.pos_a = 5'd17; cmd.req_a = 1'b1;
    n = 0;
    while (cmd.gnt_a !== 1'b1 && n < 10) begin tick(); n++; end
    tick();
    checks++;
    if (moving !== 1'b0 || cmd.gnt_a !== 1'b0 || cur_width !== 5'd17) begin
      failures++;
      $display("FAIL clamp_equal_one_cycle: mov=%0b gnt_a=%0b cur=%0d, required 0 0 17", moving, cmd.gnt_a, cur_width);
    end
    tick();
    checks++;
    if (cmd.gnt_a !== 1'b1) begin
      failures++;
      $display("FAIL clamp_equal_regrant: gnt_a=%0b, required 1", cmd.gnt_a);
    end
    cmd.req_a = 1'b0;
    tick();
  endtask

  task automatic test_enable();
    int n; int bad; int highs; bit found;
    do_reset();
    enable = 1'b0;
    cmd.pos_a = 5'd16; cmd.req_a = 1'b1;
    n = 0;
    while (cmd.gnt_a !== 1'b1 && n < 10) begin tick(); n++; end
    cmd.req_a = 1'b0;
    n = 0; bad = 0;
    while (moving !== 1'b0 && n < 6 * FRAME) begin
      if (pwm_out !== 1'b0) bad++;
      tick(); n++;
    end
    checks++;
    if (bad != 0 || cur_width !== 5'd16 || moving !== 1'b0) begin
      failures++;
      $display("FAIL enable_gated_move: pwm_high=%0d cur=%0d mov=%0b, required 0 16 0", bad, cur_width, moving);
    end
    enable = 1'b1;
    tick();
    count_frame(highs, found);
    checks++;
    if (!found || highs != 16) begin
      failures++;
      $display("FAIL enable_first_frame: high=%0d, required 16", highs);
    end
  endtask

  task automatic test_reset_mid_move();
    int n;
    do_reset();
    cmd.pos_a = 5'd17; cmd.req_a = 1'b1;
    n = 0;
    while (cmd.gnt_a !== 1'b1 && n < 10) begin tick(); n++; end
    cmd.req_a = 1'b0;
    n = 0;
    while (cur_width !== 5'd14 && n < 3 * FRAME) begin tick(); n++; end
    cmd.pos_b = 5'd10; cmd.req_b = 1'b1;
    repeat (5) tick();
    checks++;
    if (cur_width !== 5'd14 || moving !== 1'b1 || cmd.gnt_b !== 1'b0) begin
      failures++;
      $display("FAIL midmove_pending: cur=%0d mov=%0b gnt_b=%0b, required 14 1 0", cur_width, moving, cmd.gnt_b);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (cur_width !== 5'd12 || target !== 5'd12 || moving !== 1'b0 || cmd.gnt_b !== 1'b0 || pwm_out !== 1'b0) begin
      failures++;
      $display("FAIL midmove_reset: cur=%0d tgt=%0d mov=%0b gnt_b=%0b pwm=%0b, required 12 12 0 0 0",
               cur_width, target, moving, cmd.gnt_b, pwm_out);
    end
    tick(); reset = 1'b0; tick();
    checks++;
    if (cmd.gnt_b !== 1'b1 || target !== 5'd10) begin
      failures++;
      $display("FAIL midmove_regrant: gnt_b=%0b tgt=%0d, required 1 10", cmd.gnt_b, target);
    end
    cmd.req_b = 1'b0;
  endtask

  task automatic test_random();
    int shown = 0;
    do_reset();
    for (int c = 0; c < 15000; c++) begin
      checks++;
      if (cmd.gnt_a !== m_gnt_a || cmd.gnt_b !== m_gnt_b || pwm_out !== m_pwm || cur_width !== 5'(m_width) ||
          target !== 5'(m_goal) || moving !== m_busy || frame_sync !== (m_tick == 0)) begin
        failures++;
        if (shown < 10)
          $display("FAIL random_cycle%0d: gnt=%0b%0b pwm=%0b cur=%0d tgt=%0d mov=%0b fs=%0b, required %0b%0b %0b %0d %0d %0b %0b",
                   c, cmd.gnt_a, cmd.gnt_b, pwm_out, cur_width, target, moving, frame_sync,
                   m_gnt_a, m_gnt_b, m_pwm, m_width, m_goal, m_busy, m_tick == 0);
        shown++;
      end
      reset = 1'b0;
      if (cmd.gnt_a === 1'b1 || (cmd.req_a && $urandom_range(0, 999) < 3)) cmd.req_a = 1'b0;
      else if (!cmd.req_a && $urandom_range(0, 99) < 2) begin
        cmd.req_a = 1'b1; cmd.pos_a = 5'($urandom_range(0, 31));
      end
      if (cmd.gnt_b === 1'b1 || (cmd.req_b && $urandom_range(0, 999) < 3)) cmd.req_b = 1'b0;
      else if (!cmd.req_b && $urandom_range(0, 99) < 2) begin
        cmd.req_b = 1'b1; cmd.pos_b = 5'($urandom_range(0, 31));
      end
      if ($urandom_range(0, 99) == 0) enable = ~enable;
      if ($urandom_range(0, 3999) == 0) reset = 1'b1;
      tick();
    end
    reset = 1'b0; enable = 1'b1; cmd.req_a = 1'b0; cmd.req_b = 1'b0;
  endtask

  initial begin
    cmd.req_a = 1'b0; cmd.req_b = 1'b0; cmd.pos_a = 5'd0; cmd.pos_b = 5'd0;
    repeat (3) tick();
    reset = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_clamp();
    test_enable();
    test_reset_mid_move();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
